// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: function-select codes and the multiply sequencer state set.
package alu_defs_pkg;

    localparam logic [4:0] PASS_A32 = 5'b10000;
    localparam logic [4:0] ADD32    = 5'b10100;
    localparam logic [4:0] LSL32    = 5'b11011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16 unsigned multiplier that borrows the sibling 32-bit ALU
// for every add and every multiplicand shift; it owns no adder or multiplier.
module alu_mul_sequencer
    import alu_defs_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] MulA,
    input  logic [15:0] MulB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Product,
    output logic [32:0] ALU_A,
    output logic [32:0] ALU_B,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    input  logic [32:0] ALU_Out
);

    state_e      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [31:0] prod_q, prod_d;
    logic [31:0] product_q, product_d;

    // The ALU carry-out is never consulted: a 16x16 product cannot overflow 32 bits.
    logic unused_alu_msb;
    assign unused_alu_msb = ALU_Out[32];

    // State and datapath registers; reset discards any multiply in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            product_q <= product_d;
        end
    end

    // Next-state logic and ALU operand/function decode from the registered state.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        product_d  = product_q;
        ALU_A      = '0;
        ALU_B      = '0;
        ALU_FunSel = PASS_A32;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE accepts Start like IDLE so multiplies can run back to back.
                if (Start) begin
                    mcand_d   = {16'b0, MulA};
                    mplier_d  = MulB;
                    prod_d    = '0;
                    product_d = '0;
                    state_d   = STEP;
                end else begin
                    state_d   = IDLE;
                end
            end
            STEP: begin
                if (mplier_q == 16'd0) begin
                    // No set bits remain: publish the accumulated product.
                    product_d = prod_q;
                    state_d   = DONE;
                end else begin
                    if (mplier_q[0]) begin
                        ALU_A      = {1'b0, prod_q};
                        ALU_B      = {1'b0, mcand_q};
                        ALU_FunSel = ADD32;
                        prod_d     = ALU_Out[31:0];
                    end
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ALU_A      = {1'b0, mcand_q};
                ALU_FunSel = LSL32;
                mcand_d    = ALU_Out[31:0];
                // The multiplier shifts locally; the ALU is busy with the multiplicand.
                mplier_d   = mplier_q >> 1;
                state_d    = STEP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy    = (state_q == STEP) || (state_q == SHIFT);
    assign Done    = (state_q == DONE);
    assign Product = product_q;
    assign ALU_WF  = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer paired with a behavioural 32-bit ALU.
module tb_alu_mul_sequencer;
    import alu_defs_pkg::*;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [15:0] MulA;
    logic [15:0] MulB;
    logic        Busy;
    logic        Done;
    logic [31:0] Product;
    logic [32:0] ALU_A;
    logic [32:0] ALU_B;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [32:0] ALU_Out;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    alu_mul_sequencer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .MulA       (MulA),
        .MulB       (MulB),
        .Busy       (Busy),
        .Done       (Done),
        .Product    (Product),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_FunSel (ALU_FunSel),
        .ALU_WF     (ALU_WF),
        .ALU_Out    (ALU_Out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural sibling ALU.
    always_comb begin
        case (ALU_FunSel)
            PASS_A32: ALU_Out = ALU_A;
            ADD32:    ALU_Out = {1'b0, ALU_A[31:0]} + {1'b0, ALU_B[31:0]};
            LSL32:    ALU_Out = {ALU_A[31:0], 1'b0};
            default:  ALU_Out = 33'h0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int top_bits(input logic [15:0] b);
        int k = 0;
        for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    // Model: phase 0 idle, 1 busy, 2 done; cnt = busy cycles left.
    int          m_phase = 0;
    int          m_cnt = 0;
    logic [31:0] m_prod = '0;
    logic [31:0] m_pend = '0;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_prod  <= '0;
            m_pend  <= '0;
        end else if (m_phase == 1) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_phase <= 2;
                m_prod  <= m_pend;
            end
        end else if (Start) begin
            m_phase <= 1;
            m_cnt   <= 2 * top_bits(MulB) + 1;
            m_prod  <= '0;
            m_pend  <= 32'(MulA) * 32'(MulB);
        end else begin
            m_phase <= 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge Clock) begin
        if (Reset) begin
            chk("busy", 64'(Busy), 64'(m_phase == 1));
            chk("done", 64'(Done), 64'(m_phase == 2));
            chk("product", 64'(Product), 64'(m_prod));
            chk("alu_wf", 64'(ALU_WF), 64'd0);
            chk("alu_a_msb", 64'(ALU_A[32]), 64'd0);
            chk("alu_b_msb", 64'(ALU_B[32]), 64'd0);
            if (m_phase != 1) begin
                chk("idle_alu_a", 64'(ALU_A), 64'd0);
                chk("idle_alu_b", 64'(ALU_B), 64'd0);
                chk("idle_funsel", 64'(ALU_FunSel), 64'(PASS_A32));
            end
            if (Done) done_cnt++;
        end
    end

    // Drive Start for one acceptance edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic hold);
        Start = 1'b1;
        MulA  = a;
        MulB  = b;
        @(posedge Clock);
        @(negedge Clock);
        Start = hold;
    endtask

    // Counts cycles from cycle 1 until Done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!Done && cyc < 60) begin
            @(negedge Clock);
            cyc++;
        end
        if (!Done) chk("done_timeout", 64'(cyc), 64'd0);
    endtask

    int c;
    int d0;

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        MulA  = '0;
        MulB  = '0;
        #12;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_product", 64'(Product), 64'd0);
        chk("rst_funsel", 64'(ALU_FunSel), 64'(PASS_A32));
        @(negedge Clock);
        #2 Reset = 1'b1;
        @(negedge Clock);

        // 3 * 5: k=3
        issue(16'd3, 16'd5, 1'b0);
        wait_done(c);
        chk("t1_cycle", 64'(c), 64'd8);
        chk("t1_prod", 64'(Product), 64'h0000000F);
        @(negedge Clock);

        issue(16'hFFFF, 16'hFFFF, 1'b0);
        wait_done(c);
        chk("t2_cycle", 64'(c), 64'd34);
        chk("t2_prod", 64'(Product), 64'hFFFE0001);
        @(negedge Clock);

        issue(16'h1234, 16'h0000, 1'b0);
        wait_done(c);
        chk("t3_cycle", 64'(c), 64'd2);
        chk("t3_prod", 64'(Product), 64'h0);
        @(negedge Clock);

        issue(16'h0000, 16'h8000, 1'b0);
        wait_done(c);
        chk("t4_cycle", 64'(c), 64'd34);
        chk("t4_prod", 64'(Product), 64'h0);
        @(negedge Clock);

        // Start re-pulsed in cycle 3 while busy must be ignored.
        d0 = done_cnt;
        issue(16'h00AB, 16'h00FF, 1'b0);
        c = 1;
        while (!Done && c < 60) begin
            @(negedge Clock);
            c++;
            Start = (c == 3);
            if (c == 3) begin
                MulA = 16'h5555;
                MulB = 16'h0003;
            end
        end
        Start = 1'b0;
        chk("t5_cycle", 64'(c), 64'd18);
        chk("t5_prod", 64'(Product), 64'h0000AA55);
        repeat (4) @(negedge Clock);
        chk("t5_single_done", 64'(done_cnt - d0), 64'd1);

        // Reset in cycle 5 of a run.
        issue(16'h0102, 16'h00F0, 1'b0);
        repeat (4) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(Busy), 64'd0);
        chk("mid_rst_done", 64'(Done), 64'd0);
        chk("mid_rst_product", 64'(Product), 64'd0);
        chk("mid_rst_alu_a", 64'(ALU_A), 64'd0);
        chk("mid_rst_alu_b", 64'(ALU_B), 64'd0);
        chk("mid_rst_funsel", 64'(ALU_FunSel), 64'(PASS_A32));
        @(negedge Clock);
        @(negedge Clock);
        #2 Reset = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge Clock);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        issue(16'h0102, 16'h00F0, 1'b0);
        wait_done(c);
        chk("t6_cycle", 64'(c), 64'd18);
        chk("t6_prod", 64'(Product), 64'h0000F1E0);
        @(negedge Clock);

        // Start held through DONE: second run accepted on the DONE edge.
        issue(16'd2, 16'd3, 1'b1);
        MulA = 16'd7;
        MulB = 16'd9;
        wait_done(c);
        chk("t7a_cycle", 64'(c), 64'd6);
        chk("t7a_prod", 64'(Product), 64'd6);
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        chk("t7_busy_again", 64'(Busy), 64'd1);
        wait_done(c);
        chk("t7b_cycle", 64'(c), 64'd10);
        chk("t7b_prod", 64'(Product), 64'h0000003F);
        repeat (3) @(negedge Clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
